// File: rtl/pmic_pkg.sv
// Shared types and sizing helpers for the PMIC rail supervisor.
package pmic_pkg;

    typedef enum logic [2:0] {
        RAIL_OFF,
        RAIL_STARTING,
        RAIL_GOOD,
        RAIL_VFAULT,
        RAIL_IFAULT,
        RAIL_TFAULT
    } railState_t;

    // Wide enough that every counter can hold its largest threshold without wrapping.
    function automatic int counterWidth(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic isFault(input railState_t s);
        return (s == RAIL_VFAULT) || (s == RAIL_IFAULT) || (s == RAIL_TFAULT);
    endfunction

endpackage

// File: rtl/multi_rail_monitor_if.sv
// Sequencer-facing bundle of the rail supervisor: enables and comparator inputs in, status out.
interface multi_rail_monitor_if #(
    parameter int N_RAILS = 4
);
    localparam int IDX_W = pmic_pkg::idxWidth(N_RAILS);

    logic [N_RAILS-1:0] i_enable;
    logic [N_RAILS-1:0] i_voltageGood;
    logic [N_RAILS-1:0] i_currentGood;
    logic               i_clearFaults;

    logic [N_RAILS-1:0] o_railGood;
    logic [N_RAILS-1:0] o_voltageFault;
    logic [N_RAILS-1:0] o_currentFault;
    logic [N_RAILS-1:0] o_timeoutFault;
    logic               o_allGood;
    logic               o_anyFault;
    logic               o_firstFaultValid;
    logic [IDX_W-1:0]   o_firstFaultIdx;

    modport master (
        output i_enable, i_voltageGood, i_currentGood, i_clearFaults,
        input  o_railGood, o_voltageFault, o_currentFault, o_timeoutFault,
               o_allGood, o_anyFault, o_firstFaultValid, o_firstFaultIdx
    );

    modport slave (
        input  i_enable, i_voltageGood, i_currentGood, i_clearFaults,
        output o_railGood, o_voltageFault, o_currentFault, o_timeoutFault,
               o_allGood, o_anyFault, o_firstFaultValid, o_firstFaultIdx
    );

endinterface

// File: rtl/rail_channel.sv
// One rail's supervisor FSM: startup qualification, debounced error detection and latched faults.
module rail_channel
    import pmic_pkg::*;
#(
    parameter int STARTUP_DELAY   = 1000,
    parameter int ERROR_DELAY     = 100,
    parameter int STARTUP_TIMEOUT = 4000
) (
    input  logic       i_clk,
    input  logic       i_resetN,
    input  logic       i_enable,
    input  logic       i_voltageGood,
    input  logic       i_currentGood,
    input  logic       i_clearFaults,
    output railState_t o_nextState,
    output logic       o_faultEntry,
    output logic       o_railGood,
    output logic       o_voltageFault,
    output logic       o_currentFault,
    output logic       o_timeoutFault
);

    localparam int CNT_W = counterWidth(STARTUP_TIMEOUT, STARTUP_DELAY, ERROR_DELAY);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] STAB_LAST    = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(STARTUP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ERROR_LAST   = CNT_W'(ERROR_DELAY - 1);

    railState_t       state;
    railState_t       nextState;
    logic [CNT_W-1:0] stabCnt;
    logic [CNT_W-1:0] timeoutCnt;
    logic [CNT_W-1:0] vErrCnt;
    logic [CNT_W-1:0] iErrCnt;
    logic             bothGood;

    assign bothGood = i_voltageGood & i_currentGood;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Losing the enable beats every other transition; voltage beats current when both trip together.
    always_comb begin
        nextState = state;
        case (state)
            RAIL_OFF: begin
                if (i_enable) nextState = RAIL_STARTING;
            end
            RAIL_STARTING: begin
                if (!i_enable)                              nextState = RAIL_OFF;
                else if (bothGood && stabCnt == STAB_LAST)  nextState = RAIL_GOOD;
                else if (timeoutCnt == TIMEOUT_LAST)        nextState = RAIL_TFAULT;
            end
            RAIL_GOOD: begin
                if (!i_enable)                                  nextState = RAIL_OFF;
                else if (!i_voltageGood && vErrCnt == ERROR_LAST) nextState = RAIL_VFAULT;
                else if (!i_currentGood && iErrCnt == ERROR_LAST) nextState = RAIL_IFAULT;
            end
            RAIL_VFAULT, RAIL_IFAULT, RAIL_TFAULT: begin
                if (i_clearFaults) nextState = RAIL_OFF;
            end
            default: nextState = RAIL_OFF;
        endcase
    end

    assign o_nextState  = nextState;
    assign o_faultEntry = isFault(nextState) && !isFault(state);

    // Outputs decode the next state so they change on the same edge as the state itself.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            state          <= RAIL_OFF;
            stabCnt        <= '0;
            timeoutCnt     <= '0;
            vErrCnt        <= '0;
            iErrCnt        <= '0;
            o_railGood     <= 1'b0;
            o_voltageFault <= 1'b0;
            o_currentFault <= 1'b0;
            o_timeoutFault <= 1'b0;
        end else begin
            state          <= nextState;
            o_railGood     <= (nextState == RAIL_GOOD);
            o_voltageFault <= (nextState == RAIL_VFAULT);
            o_currentFault <= (nextState == RAIL_IFAULT);
            o_timeoutFault <= (nextState == RAIL_TFAULT);
            if (nextState != state) begin
                stabCnt    <= '0;
                timeoutCnt <= '0;
                vErrCnt    <= '0;
                iErrCnt    <= '0;
            end else begin
                stabCnt    <= (state == RAIL_STARTING && bothGood) ? satInc(stabCnt) : '0;
                timeoutCnt <= (state == RAIL_STARTING) ? satInc(timeoutCnt) : '0;
                vErrCnt    <= (state == RAIL_GOOD && !i_voltageGood) ? satInc(vErrCnt) : '0;
                iErrCnt    <= (state == RAIL_GOOD && !i_currentGood) ? satInc(iErrCnt) : '0;
            end
        end
    end

endmodule

// File: rtl/multi_rail_monitor.sv
// Supervisor for N_RAILS PMIC rails: per-rail channels plus aggregate flags and first-fault capture.
module multi_rail_monitor
    import pmic_pkg::*;
#(
    parameter int N_RAILS         = 4,
    parameter int STARTUP_DELAY   = 1000,
    parameter int ERROR_DELAY     = 100,
    parameter int STARTUP_TIMEOUT = 4000
) (
    input  logic                 i_clk,
    input  logic                 i_resetN,
    multi_rail_monitor_if.slave  bus
);

    localparam int IDX_W = idxWidth(N_RAILS);

    if (N_RAILS < 1 || N_RAILS > 16) begin : gBadRails
        $error("multi_rail_monitor: N_RAILS must be within 1..16");
    end
    if (STARTUP_DELAY < 1) begin : gBadStartup
        $error("multi_rail_monitor: STARTUP_DELAY must be at least 1");
    end
    if (ERROR_DELAY < 1) begin : gBadError
        $error("multi_rail_monitor: ERROR_DELAY must be at least 1");
    end
    if (STARTUP_TIMEOUT <= STARTUP_DELAY) begin : gBadTimeout
        $error("multi_rail_monitor: STARTUP_TIMEOUT must exceed STARTUP_DELAY");
    end

    railState_t         nextState [N_RAILS];
    logic [N_RAILS-1:0] nextGood;
    logic [N_RAILS-1:0] nextFault;
    logic [N_RAILS-1:0] faultEntry;
    logic [N_RAILS-1:0] railGood;
    logic [N_RAILS-1:0] voltageFault;
    logic [N_RAILS-1:0] currentFault;
    logic [N_RAILS-1:0] timeoutFault;
    logic [IDX_W-1:0]   entryIdx;
    logic               allGood;
    logic               anyFault;
    logic               firstFaultValid;
    logic [IDX_W-1:0]   firstFaultIdx;

    for (genvar n = 0; n < N_RAILS; n++) begin : gRail
        rail_channel #(
            .STARTUP_DELAY   (STARTUP_DELAY),
            .ERROR_DELAY     (ERROR_DELAY),
            .STARTUP_TIMEOUT (STARTUP_TIMEOUT)
        ) uChannel (
            .i_clk          (i_clk),
            .i_resetN       (i_resetN),
            .i_enable       (bus.i_enable[n]),
            .i_voltageGood  (bus.i_voltageGood[n]),
            .i_currentGood  (bus.i_currentGood[n]),
            .i_clearFaults  (bus.i_clearFaults),
            .o_nextState    (nextState[n]),
            .o_faultEntry   (faultEntry[n]),
            .o_railGood     (railGood[n]),
            .o_voltageFault (voltageFault[n]),
            .o_currentFault (currentFault[n]),
            .o_timeoutFault (timeoutFault[n])
        );

        assign nextGood[n]  = (nextState[n] == RAIL_GOOD);
        assign nextFault[n] = isFault(nextState[n]);
    end

    // Scanning downward leaves the lowest-numbered newly faulting rail.
    always_comb begin
        entryIdx = '0;
        for (int n = N_RAILS - 1; n >= 0; n--) begin
            if (faultEntry[n]) entryIdx = IDX_W'(n);
        end
    end

    // A fault arriving with a clear is captured, since the clear frees the slot on that edge.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            allGood         <= 1'b0;
            anyFault        <= 1'b0;
            firstFaultValid <= 1'b0;
            firstFaultIdx   <= '0;
        end else begin
            allGood  <= &nextGood;
            anyFault <= |nextFault;
            if (|faultEntry && (!firstFaultValid || bus.i_clearFaults)) begin
                firstFaultValid <= 1'b1;
                firstFaultIdx   <= entryIdx;
            end else if (bus.i_clearFaults) begin
                firstFaultValid <= 1'b0;
                firstFaultIdx   <= '0;
            end
        end
    end

    assign bus.o_railGood        = railGood;
    assign bus.o_voltageFault    = voltageFault;
    assign bus.o_currentFault    = currentFault;
    assign bus.o_timeoutFault    = timeoutFault;
    assign bus.o_allGood         = allGood;
    assign bus.o_anyFault        = anyFault;
    assign bus.o_firstFaultValid = firstFaultValid;
    assign bus.o_firstFaultIdx   = firstFaultIdx;

endmodule

// File: tb/tb_multi_rail_monitor.sv
// Bench for multi_rail_monitor: directed scenarios plus randomized traffic against a run-length rail model.
module tb_multi_rail_monitor;

    localparam int NR = 4;
    localparam int SD = 8;
    localparam int ED = 3;
    localparam int ST = 20;

    localparam int M_OFF   = 0;
    localparam int M_START = 1;
    localparam int M_GOOD  = 2;
    localparam int M_VF    = 3;
    localparam int M_IF    = 4;
    localparam int M_TF    = 5;

    logic clk = 1'b0;
    logic resetN;
    int   checkCount = 0;
    int   passCount  = 0;

    multi_rail_monitor_if #(.N_RAILS(NR)) bus ();

    multi_rail_monitor #(
        .N_RAILS         (NR),
        .STARTUP_DELAY   (SD),
        .ERROR_DELAY     (ED),
        .STARTUP_TIMEOUT (ST)
    ) dut (
        .i_clk    (clk),
        .i_resetN (resetN),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Model: each rail tracks its mode and how long the relevant conditions have persisted.
    int mode [NR];
    int goodRun [NR];
    int elapsed [NR];
    int vBad [NR];
    int iBad [NR];
    int nMode [NR];
    int nGoodRun [NR];
    int nElapsed [NR];
    int nVBad [NR];
    int nIBad [NR];
    bit mValid, nValid, entryAny;
    int mIdx, nIdx, entryLow;

    always_comb begin
        entryAny = 1'b0;
        entryLow = 0;
        for (int n = 0; n < NR; n++) begin
            nMode[n] = mode[n];
            case (mode[n])
                M_OFF:   if (bus.i_enable[n]) nMode[n] = M_START;
                M_START: begin
                    if (!bus.i_enable[n]) nMode[n] = M_OFF;
                    else if (bus.i_voltageGood[n] && bus.i_currentGood[n] && goodRun[n] + 1 >= SD)
                        nMode[n] = M_GOOD;
                    else if (elapsed[n] + 1 >= ST) nMode[n] = M_TF;
                end
                M_GOOD: begin
                    if (!bus.i_enable[n]) nMode[n] = M_OFF;
                    else if (!bus.i_voltageGood[n] && vBad[n] + 1 >= ED) nMode[n] = M_VF;
                    else if (!bus.i_currentGood[n] && iBad[n] + 1 >= ED) nMode[n] = M_IF;
                end
                default: if (bus.i_clearFaults) nMode[n] = M_OFF;
            endcase
            if (nMode[n] != mode[n]) begin
                nGoodRun[n] = 0;
                nElapsed[n] = 0;
                nVBad[n]    = 0;
                nIBad[n]    = 0;
            end else begin
                nGoodRun[n] = (bus.i_voltageGood[n] && bus.i_currentGood[n]) ? goodRun[n] + 1 : 0;
                nElapsed[n] = elapsed[n] + 1;
                nVBad[n]    = bus.i_voltageGood[n] ? 0 : vBad[n] + 1;
                nIBad[n]    = bus.i_currentGood[n] ? 0 : iBad[n] + 1;
            end
            if (nMode[n] >= M_VF && mode[n] < M_VF && !entryAny) begin
                entryAny = 1'b1;
                entryLow = n;
            end
        end
        nValid = mValid;
        nIdx   = mIdx;
        if (entryAny && (!mValid || bus.i_clearFaults)) begin
            nValid = 1'b1;
            nIdx   = entryLow;
        end else if (bus.i_clearFaults) begin
            nValid = 1'b0;
            nIdx   = 0;
        end
    end

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int n = 0; n < NR; n++) begin
                mode[n]    <= M_OFF;
                goodRun[n] <= 0;
                elapsed[n] <= 0;
                vBad[n]    <= 0;
                iBad[n]    <= 0;
            end
            mValid <= 1'b0;
            mIdx   <= 0;
        end else begin
            mode    <= nMode;
            goodRun <= nGoodRun;
            elapsed <= nElapsed;
            vBad    <= nVBad;
            iBad    <= nIBad;
            mValid  <= nValid;
            mIdx    <= nIdx;
        end
    end

    logic [NR-1:0] expGood, expV, expI, expT;
    logic          expAllGood, expAnyFault;

    always_comb begin
        expGood = '0;
        expV    = '0;
        expI    = '0;
        expT    = '0;
        for (int n = 0; n < NR; n++) begin
            expGood[n] = (mode[n] == M_GOOD);
            expV[n]    = (mode[n] == M_VF);
            expI[n]    = (mode[n] == M_IF);
            expT[n]    = (mode[n] == M_TF);
        end
        expAllGood  = (expGood == '1);
        expAnyFault = ((expV | expI | expT) != '0);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        checkOutput("railGood",        int'(bus.o_railGood),        int'(expGood));
        checkOutput("voltageFault",    int'(bus.o_voltageFault),    int'(expV));
        checkOutput("currentFault",    int'(bus.o_currentFault),    int'(expI));
        checkOutput("timeoutFault",    int'(bus.o_timeoutFault),    int'(expT));
        checkOutput("allGood",         int'(bus.o_allGood),         int'(expAllGood));
        checkOutput("anyFault",        int'(bus.o_anyFault),        int'(expAnyFault));
        checkOutput("firstFaultValid", int'(bus.o_firstFaultValid), int'(mValid));
        checkOutput("firstFaultIdx",   int'(bus.o_firstFaultIdx),   mIdx);
    end

    task automatic applyStimulus(input logic [NR-1:0] en, input logic [NR-1:0] vg,
                                 input logic [NR-1:0] cg, input logic clr);
        bus.i_enable      = en;
        bus.i_voltageGood = vg;
        bus.i_currentGood = cg;
        bus.i_clearFaults = clr;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " railGood"}, int'(bus.o_railGood), 0);
        checkOutput({tag, " faults"},
                    int'(bus.o_voltageFault | bus.o_currentFault | bus.o_timeoutFault), 0);
        checkOutput({tag, " allGood"}, int'(bus.o_allGood), 0);
        checkOutput({tag, " anyFault"}, int'(bus.o_anyFault), 0);
        checkOutput({tag, " ffValid"}, int'(bus.o_firstFaultValid), 0);
        checkOutput({tag, " ffIdx"}, int'(bus.o_firstFaultIdx), 0);
    endtask

    logic [NR-1:0] rEn, rV, rC;
    bit            noisy;

    initial begin
        applyStimulus('0, '0, '0, 1'b0);
        resetN = 1'b1;
        #2 resetN = 1'b0;
        #1 checkAllZero("reset");
        waitNeg(2);
        resetN = 1'b1;

        // All rails enabled with goods held high.
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
        waitNeg(SD);
        checkOutput("startup early railGood", int'(bus.o_railGood), 0);
        waitNeg(1);
        checkOutput("startup railGood", int'(bus.o_railGood), 'hF);
        checkOutput("startup allGood", int'(bus.o_allGood), 1);
        checkOutput("startup anyFault", int'(bus.o_anyFault), 0);

        // Two-cycle voltage glitch on rail 2 is filtered; three cycles latch.
        applyStimulus(4'hF, 4'b1011, 4'hF, 1'b0);
        waitNeg(2);
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
        waitNeg(3);
        checkOutput("glitch voltageFault", int'(bus.o_voltageFault), 0);
        checkOutput("glitch allGood", int'(bus.o_allGood), 1);
        applyStimulus(4'hF, 4'b1011, 4'hF, 1'b0);
        waitNeg(2);
        checkOutput("vfault early", int'(bus.o_voltageFault), 0);
        waitNeg(1);
        checkOutput("vfault rail2", int'(bus.o_voltageFault), 'b0100);
        checkOutput("vfault idx", int'(bus.o_firstFaultIdx), 2);
        checkOutput("vfault valid", int'(bus.o_firstFaultValid), 1);
        checkOutput("vfault allGood", int'(bus.o_allGood), 0);

        // Rail 1 loses voltage and current together: voltage wins.
        applyStimulus(4'hF, 4'b1001, 4'b1101, 1'b0);
        waitNeg(ED);
        checkOutput("both low voltageFault", int'(bus.o_voltageFault), 'b0110);
        checkOutput("both low currentFault", int'(bus.o_currentFault), 0);
        checkOutput("both low idx kept", int'(bus.o_firstFaultIdx), 2);

        applyStimulus(4'hF, 4'hF, 4'hF, 1'b1);
        waitNeg(1);
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
        checkOutput("clear anyFault", int'(bus.o_anyFault), 0);
        checkOutput("clear valid", int'(bus.o_firstFaultValid), 0);
        waitNeg(SD);
        checkOutput("restart partial", int'(bus.o_railGood), 'b1001);
        waitNeg(1);
        checkOutput("restart railGood", int'(bus.o_railGood), 'hF);

        // Rail 0 alone with a voltage toggling every 4 cycles times out.
        applyStimulus('0, 4'hF, 4'hF, 1'b0);
        waitNeg(2);
        for (int k = 0; k <= ST; k++) begin
            applyStimulus(4'b0001, {3'b111, ((k / 4) % 2 == 0) ? 1'b1 : 1'b0}, 4'hF, 1'b0);
            waitNeg(1);
            if (k == ST - 1) checkOutput("timeout early", int'(bus.o_timeoutFault), 0);
        end
        checkOutput("timeout rail0", int'(bus.o_timeoutFault), 'b0001);
        checkOutput("timeout idx", int'(bus.o_firstFaultIdx), 0);
        checkOutput("timeout valid", int'(bus.o_firstFaultValid), 1);

        applyStimulus(4'hF, 4'hF, 4'hF, 1'b1);
        waitNeg(1);
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
        waitNeg(SD + 4);
        checkOutput("all good again", int'(bus.o_allGood), 1);

        // Rails 3 and 1 fault on the same edge; the lower index is captured.
        applyStimulus(4'hF, 4'b0111, 4'b1101, 1'b0);
        waitNeg(ED);
        checkOutput("dual voltageFault", int'(bus.o_voltageFault), 'b1000);
        checkOutput("dual currentFault", int'(bus.o_currentFault), 'b0010);
        checkOutput("dual idx", int'(bus.o_firstFaultIdx), 1);
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
        waitNeg(1);
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b1);
        waitNeg(1);
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
        checkOutput("dual clear anyFault", int'(bus.o_anyFault), 0);
        checkOutput("dual clear railGood", int'(bus.o_railGood), 'b0101);
        waitNeg(SD);
        checkOutput("dual restart partial", int'(bus.o_railGood), 'b0101);
        waitNeg(1);
        checkOutput("dual restart allGood", int'(bus.o_allGood), 1);

        // Enable dropped during startup, then reset asserted mid-count.
        applyStimulus('0, 4'hF, 4'hF, 1'b0);
        waitNeg(2);
        applyStimulus(4'hF, 4'b1000, 4'b1000, 1'b0);
        waitNeg(5);
        applyStimulus(4'b1011, 4'b1000, 4'b1000, 1'b0);
        waitNeg(5);
        checkOutput("disable railGood", int'(bus.o_railGood), 'b1000);
        checkOutput("disable anyFault", int'(bus.o_anyFault), 0);
        resetN = 1'b0;
        #1 checkAllZero("midreset");
        waitNeg(2);
        resetN = 1'b1;
        waitNeg(SD + 1);
        checkOutput("post reset railGood", int'(bus.o_railGood), 'b1000);
        checkOutput("post reset anyFault", int'(bus.o_anyFault), 0);

        // Randomized traffic, checked every cycle by the model.
        rEn   = 4'hF;
        noisy = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 100 == 0) noisy = ($urandom_range(0, 1) == 1);
            rV = '1;
            rC = '1;
            for (int b = 0; b < NR; b++) begin
                if ($urandom_range(0, 31) == 0) rEn[b] = ~rEn[b];
                if ($urandom_range(0, noisy ? 3 : 40) == 0) rV[b] = 1'b0;
                if ($urandom_range(0, noisy ? 3 : 40) == 0) rC[b] = 1'b0;
            end
            applyStimulus(rEn, rV, rC, ($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 499) == 0) begin
                resetN = 1'b0;
                waitNeg(1);
                resetN = 1'b1;
            end else begin
                waitNeg(1);
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
